// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction-fetch stage sitting in front of the unified ROM. It owns the
// fetch PC, drives the two combinational ROM read ports with consecutive
// word addresses, captures up to two instructions per cycle into a small
// FIFO and hands them to decode one at a time over valid/ready.
//
// Ports:
//   i_CLK            clock, all state updates on the rising edge
//   i_RSTn           asynchronous active-low reset
//   i_CE             fetch enable (gates pushes only)
//   o_PC_0 / o_PC_1  ROM word addresses: fetch_pc>>2 and (fetch_pc+4)>>2
//   i_INSTRUCTION_0/1 combinational ROM data for o_PC_0 / o_PC_1
//   i_REDIRECT       flush the queue and restart fetch at i_REDIRECT_PC
//   i_REDIRECT_PC    byte target PC of the redirect
//   o_VALID          queue head valid (forced low during a redirect)
//   o_INSTRUCTION    head instruction, 0 when empty
//   o_PC             byte PC of the head instruction, 0 when empty
//   i_READY          decode accepts the head this cycle
//   o_COUNT          current occupancy
// ----------------------------------------------------------------------------
module ifetch_queue #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                             i_CLK,
  input  logic                             i_RSTn,
  input  logic                             i_CE,
  output logic [ADDR_WIDTH-1:0]            o_PC_0,
  output logic [ADDR_WIDTH-1:0]            o_PC_1,
  input  logic [DATA_WIDTH-1:0]            i_INSTRUCTION_0,
  input  logic [DATA_WIDTH-1:0]            i_INSTRUCTION_1,
  input  logic                             i_REDIRECT,
  input  logic [ADDR_WIDTH-1:0]            i_REDIRECT_PC,
  output logic                             o_VALID,
  output logic [DATA_WIDTH-1:0]            o_INSTRUCTION,
  output logic [ADDR_WIDTH-1:0]            o_PC,
  input  logic                             i_READY,
  output logic [$clog2(QUEUE_DEPTH):0]     o_COUNT
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  // State
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;

  // FIFO storage (not reset: occupancy alone defines what is valid)
  logic [DATA_WIDTH-1:0] inst_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_pc_plus4;
  logic [PTR_W-1:0]      wr_ptr_plus1;
  logic [CNT_W-1:0]      free_slots;
  logic [1:0]            push_n;
  logic                  pop;
  logic                  not_empty;

  // Redirect targets are word aligned; the two low bits are simply dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_REDIRECT_PC[1:0];

  assign fetch_pc_plus4 = fetch_pc_q + ADDR_WIDTH'(4);
  assign wr_ptr_plus1   = wr_ptr_q + PTR_W'(1);
  assign not_empty      = (count_q != '0);

  // Space is judged from the start-of-cycle count; a same-cycle pop does
  // not make room for an extra push.
  assign free_slots = DEPTH_C - count_q;

  always_comb begin
    push_n = 2'd0;
    if (i_CE && !i_REDIRECT) begin
      if (free_slots >= CNT_W'(2)) begin
        push_n = 2'd2;
      end else if (free_slots == CNT_W'(1)) begin
        push_n = 2'd1;
      end
    end
  end

  // o_VALID already excludes the redirect cycle, so pop needs no extra term.
  assign o_VALID = not_empty && !i_REDIRECT;
  assign pop     = o_VALID && i_READY;

  always_comb begin
    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'({push_n, 2'b00});
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_n);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push_n) - CNT_W'(pop);
    if (i_REDIRECT) begin
      fetch_pc_d = {i_REDIRECT_PC[ADDR_WIDTH-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Port 0 data always lands first; port 1 follows in the next slot.
  always_ff @(posedge i_CLK) begin
    if (push_n != 2'd0) begin
      inst_mem[wr_ptr_q] <= i_INSTRUCTION_0;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
    if (push_n == 2'd2) begin
      inst_mem[wr_ptr_plus1] <= i_INSTRUCTION_1;
      pc_mem[wr_ptr_plus1]   <= fetch_pc_plus4;
    end
  end

  assign o_PC_0        = fetch_pc_q >> 2;
  assign o_PC_1        = fetch_pc_plus4 >> 2;
  assign o_INSTRUCTION = not_empty ? inst_mem[rd_ptr_q] : '0;
  assign o_PC          = not_empty ? pc_mem[rd_ptr_q]   : '0;
  assign o_COUNT       = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Drives ifetch_queue with directed and randomized fetch/decode/redirect
// traffic and compares every output each cycle against a queue-of-PCs model.
// A second instance with RESET_PC near the top of the address space checks
// PC wrap-around from reset.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] W_RST_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          ce, redir, ready;
  logic [31:0]   redir_pc;

  logic [31:0]   pc0, pc1, inst0, inst1, inst_o, pc_o;
  logic          valid;
  logic [CW-1:0] count;

  logic [31:0]   w_pc0, w_pc1, w_inst0, w_inst1, w_inst_o, w_pc_o;
  logic          w_valid;
  logic [CW-1:0] w_count;

  // ROM contents: a fixed, easily recognisable function of the word address.
  function automatic logic [31:0] rom(input logic [31:0] w);
    return w ^ 32'hC3A5_0000;
  endfunction

  assign inst0   = rom(pc0);
  assign inst1   = rom(pc1);
  assign w_inst0 = rom(w_pc0);
  assign w_inst1 = rom(w_pc1);

  ifetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_CE(ce),
    .o_PC_0(pc0), .o_PC_1(pc1),
    .i_INSTRUCTION_0(inst0), .i_INSTRUCTION_1(inst1),
    .i_REDIRECT(redir), .i_REDIRECT_PC(redir_pc),
    .o_VALID(valid), .o_INSTRUCTION(inst_o), .o_PC(pc_o),
    .i_READY(ready), .o_COUNT(count)
  );

  ifetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(DEPTH), .RESET_PC(W_RST_PC)) dut_w (
    .i_CLK(clk), .i_RSTn(rst_n), .i_CE(1'b1),
    .o_PC_0(w_pc0), .o_PC_1(w_pc1),
    .i_INSTRUCTION_0(w_inst0), .i_INSTRUCTION_1(w_inst1),
    .i_REDIRECT(1'b0), .i_REDIRECT_PC(32'h0),
    .o_VALID(w_valid), .o_INSTRUCTION(w_inst_o), .o_PC(w_pc_o),
    .i_READY(1'b1), .o_COUNT(w_count)
  );

  // Reference model: fetch PC plus an ordered queue of the byte PCs held.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Wrap-instance tracking: expected first four head PCs after reset.
  logic [31:0] w_exp [4];
  int          w_idx = 0;
  logic        w_started = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_pc1;
    exp_pc1 = m_pc + 32'd4;
    chk("valid", 32'(valid), 32'((m_q.size() > 0) && !redir));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("pc0",   pc0, m_pc >> 2);
    chk("pc1",   pc1, exp_pc1 >> 2);
    if (m_q.size() == 0) begin
      chk("empty_inst", inst_o, 32'h0);
      chk("empty_pc",   pc_o,   32'h0);
    end else if (!redir) begin
      chk("head_pc",   pc_o,   m_q[0]);
      chk("head_inst", inst_o, rom(m_q[0] >> 2));
    end
    // Wrap instance: PCs must run F8, FC, 0, 4 with no gaps once valid.
    if (!rst_n) begin
      chk("wrap_pc1_rst", w_pc1, 32'h3FFF_FFFF);
    end else if (w_idx < 4) begin
      if (w_valid) begin
        w_started = 1'b1;
        chk("wrap_pc",   w_pc_o,   w_exp[w_idx]);
        chk("wrap_inst", w_inst_o, rom(w_exp[w_idx] >> 2));
        w_idx++;
      end else if (w_started) begin
        chk("wrap_gap", 32'(w_valid), 32'h1);
      end
    end
  endtask

  task automatic model_edge();
    int free_n, push_n;
    if (!rst_n) begin
      m_q.delete();
      m_pc = RST_PC;
    end else if (redir) begin
      m_q.delete();
      m_pc = redir_pc & ~32'h3;
      $display("redirect target=%08h", m_pc);
    end else begin
      free_n = DEPTH - m_q.size();
      push_n = ce ? ((free_n >= 2) ? 2 : free_n) : 0;
      if ((m_q.size() > 0) && ready) begin
        $display("pop pc=%08h inst=%08h", m_q[0], rom(m_q[0] >> 2));
        void'(m_q.pop_front());
      end
      for (int k = 0; k < push_n; k++) m_q.push_back(m_pc + 32'(4 * k));
      m_pc = m_pc + 32'(4 * push_n);
    end
  endtask

  // One clock: drive inputs, compare mid-cycle, advance the model at the edge.
  task automatic cycle(input logic ce_v, input logic ready_v, input logic redir_v,
                       input logic [31:0] tgt);
    ce = ce_v; ready = ready_v; redir = redir_v; redir_pc = tgt;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    w_exp[0] = 32'hFFFF_FFF8; w_exp[1] = 32'hFFFF_FFFC;
    w_exp[2] = 32'h0000_0000; w_exp[3] = 32'h0000_0004;
    rst_n = 1'b0; ce = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = '0;
    m_pc = RST_PC;

    // Reset state
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // Streaming from reset with decode always ready
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    // Decode stalls: queue fills and fetch PC holds
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    // Pops from full: single-word pushes keep count at DEPTH-1
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("steady_count", 32'(count), 32'd3);
    // Redirect with a misaligned target while entries are queued
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    // Redirect with fetch disabled and decode ready
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_2000);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    // Redirect to the last word: ROM port 1 address wraps to 0
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) == 0), tgt);
    end

    // Asynchronous reset mid-stream with three entries queued
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 32'h0);
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_pc0",   pc0,        RST_PC >> 2);
    m_q.delete();
    m_pc = RST_PC;
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    chk("wrap_seen", 32'(w_idx), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
